// File: rtl/rtc_bus_sequencer.sv
// RTC bus sequencer: drives one multiplexed address/data bus cycle
// (address phase, gap, data phase) with T_PHASE cycles per phase.
module rtc_bus_sequencer #(
  parameter int unsigned T_PHASE = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  input  logic [7:0] bus_in,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic [7:0] rdata,
  output logic       cs,
  output logic       rd,
  output logic       wr,
  output logic       ad,
  output logic       enable,
  output logic       busy,
  output logic       done
);

  typedef enum logic [3:0] {
    IDLE, A_SETUP, A_STROBE, A_HOLD, GAP,
    D_SETUP, D_STROBE, D_HOLD, DONE
  } state_e;

  localparam logic [7:0] LAST = 8'(T_PHASE - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] addr_q, wdata_q, rdata_q;
  logic       rw_q;
  logic       phase_end;

  assign phase_end = (cnt_q == LAST);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (start) state_d = A_SETUP;
      A_SETUP:  if (phase_end) state_d = A_STROBE;
      A_STROBE: if (phase_end) state_d = A_HOLD;
      A_HOLD:   if (phase_end) state_d = GAP;
      GAP:      if (phase_end) state_d = D_SETUP;
      D_SETUP:  if (phase_end) state_d = D_STROBE;
      D_STROBE: if (phase_end) state_d = D_HOLD;
      D_HOLD:   if (phase_end) state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Counter restarts on every state change so each phase is exactly T_PHASE.
  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if (state_d != state_q || state_q == IDLE)
      cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && start) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        rw_q    <= rw;
      end
      if (state_q == D_STROBE && phase_end && rw_q)
        rdata_q <= bus_in;
    end
  end

  always_comb begin
    cs      = 1'b1;
    rd      = 1'b1;
    wr      = 1'b1;
    ad      = 1'b1;
    bus_oe  = 1'b0;
    bus_out = '0;
    enable  = 1'b0;
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    unique case (1'b1)
      (state_q == A_SETUP),
      (state_q == A_HOLD),
      (state_q == A_STROBE): begin
        cs      = 1'b0;
        ad      = 1'b0;
        wr      = (state_q != A_STROBE);
        bus_oe  = 1'b1;
        bus_out = addr_q;
        enable  = 1'b1;
      end
      (state_q == GAP): enable = 1'b1;
      (state_q == D_SETUP),
      (state_q == D_HOLD),
      (state_q == D_STROBE): begin
        cs      = 1'b0;
        enable  = 1'b1;
        bus_oe  = !rw_q;
        bus_out = rw_q ? 8'h00 : wdata_q;
        if (state_q == D_STROBE) begin
          rd = !rw_q;
          wr = rw_q;
        end
      end
      default: ;
    endcase
  end

  assign rdata = rdata_q;

endmodule
